// File: rtl/alu_sequencer.sv
// alu_sequencer: walks a small program RAM of {op, imm} steps, feeding each
// step to an external combinational ALU as acc <- ALU(op, acc, imm). It
// gathers sticky overflow/BAF flags and the final zero flag for the host.

module alu_sequencer #(
    parameter int         DEPTH  = 8,
    parameter int         AW     = 3,
    parameter logic [3:0] END_OP = 4'b0001
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [3:0]    prog_op,
    input  logic [5:0]    prog_imm,
    input  logic          start,
    input  logic [5:0]    acc_init,
    output logic          busy,
    output logic          done,
    output logic [5:0]    result,
    output logic          iof_sticky,
    output logic          baf_sticky,
    output logic          zf_last,
    output logic [AW:0]   steps,
    output logic [5:0]    alu_x,
    output logic [5:0]    alu_y,
    output logic [3:0]    alu_op,
    input  logic [5:0]    alu_z,
    input  logic          alu_iof,
    input  logic          alu_baf,
    input  logic          alu_zf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [5:0]    acc_q;
    logic          iof_q;
    logic          baf_q;
    logic          zf_q;
    logic [AW:0]   steps_q;
    logic [AW:0]   steps_d;

    // Program storage is deliberately not reset; the host loads it before use.
    logic [9:0]    prog_q [DEPTH];

    logic [3:0]    curOp;
    logic [5:0]    curImm;
    logic          isEnd;
    logic          lastSlot;
    logic          running;

    assign {curOp, curImm} = prog_q[pc_q];
    assign isEnd    = (curOp == END_OP);
    assign lastSlot = (pc_q == AW'(DEPTH - 1));
    assign running  = (state_q == RUN);

    // The last slot never advances the pc, so the program cannot wrap around.
    assign pc_d    = lastSlot ? pc_q : pc_q + AW'(1);
    assign steps_d = steps_q + (AW+1)'(1);

    assign busy       = running;
    assign done       = (state_q == DONE);
    assign result     = acc_q;
    assign iof_sticky = iof_q;
    assign baf_sticky = baf_q;
    assign zf_last    = zf_q;
    assign steps      = steps_q;

    // The terminator is never presented to the ALU; it sees a harmless op 0 instead.
    assign alu_x  = acc_q;
    assign alu_y  = running ? curImm : 6'd0;
    assign alu_op = (running && !isEnd) ? curOp : 4'b0000;

    // Program writes are accepted whenever a run is not in progress.
    always_ff @(posedge clk) begin
        if (prog_we && (state_q != RUN)) begin
            prog_q[prog_addr] <= {prog_op, prog_imm};
        end
    end

    // Run control: seed on start, one ALU step per cycle, one-cycle DONE pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            iof_q   <= 1'b0;
            baf_q   <= 1'b0;
            zf_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= acc_init;
                        pc_q    <= '0;
                        steps_q <= '0;
                        iof_q   <= 1'b0;
                        baf_q   <= 1'b0;
                        zf_q    <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (isEnd) begin
                        state_q <= DONE;
                    end else begin
                        acc_q   <= alu_z;
                        iof_q   <= iof_q | alu_iof;
                        baf_q   <= baf_q | alu_baf;
                        zf_q    <= alu_zf;
                        steps_q <= steps_d;
                        pc_q    <= pc_d;
                        if (lastSlot) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with a behavioural 6-bit ALU and
// checks every run against a program-level reference model.

module tb_alu_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_END  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_INC  = 4'd3;
    localparam logic [3:0] OP_DEC  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_EQ   = 4'd11;
    localparam logic [3:0] OP_LT   = 4'd12;
    localparam logic [3:0] OP_GT   = 4'd13;
    localparam logic [3:0] OP_NEG  = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

    logic          clk;
    logic          rst_n;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [3:0]    prog_op;
    logic [5:0]    prog_imm;
    logic          start;
    logic [5:0]    acc_init;
    logic          busy;
    logic          done;
    logic [5:0]    result;
    logic          iof_sticky;
    logic          baf_sticky;
    logic          zf_last;
    logic [AW:0]   steps;
    logic [5:0]    alu_x;
    logic [5:0]    alu_y;
    logic [3:0]    alu_op;
    logic [5:0]    alu_z;
    logic          alu_iof;
    logic          alu_baf;
    logic          alu_zf;

    int checks;
    int errors;
    int endSeen;

    logic [9:0] progModel [DEPTH];

    alu_sequencer #(.DEPTH(DEPTH), .AW(AW), .END_OP(OP_END)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op), .prog_imm(prog_imm),
        .start(start), .acc_init(acc_init),
        .busy(busy), .done(done), .result(result),
        .iof_sticky(iof_sticky), .baf_sticky(baf_sticky), .zf_last(zf_last), .steps(steps),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_z(alu_z), .alu_iof(alu_iof), .alu_baf(alu_baf), .alu_zf(alu_zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {iof, baf, zf, z}; baf reflects the result sign bit.
    function automatic logic [8:0] aluModel(input logic [3:0] op, input logic [5:0] x, input logic [5:0] y);
        int sx;
        int sy;
        int r;
        logic [5:0] z;
        logic iof;
        sx  = $signed(x);
        sy  = $signed(y);
        r   = 0;
        iof = 1'b0;
        z   = 6'd0;
        case (op)
            OP_ADD:  r = sx + sy;
            OP_SUB:  r = sx - sy;
            OP_INC:  r = sx + 1;
            OP_DEC:  r = sx - 1;
            OP_NEG:  r = -sx;
            default: r = 0;
        endcase
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG: begin
                z   = r[5:0];
                iof = (r > 31) || (r < -32);
            end
            OP_AND:  z = x & y;
            OP_OR:   z = x | y;
            OP_XOR:  z = x ^ y;
            OP_NOT:  z = ~x;
            OP_SHL:  z = {x[4:0], 1'b0};
            OP_SHR:  z = {1'b0, x[5:1]};
            OP_EQ:   z = (x == y) ? 6'd1 : 6'd0;
            OP_LT:   z = (x < y) ? 6'd1 : 6'd0;
            OP_GT:   z = (x > y) ? 6'd1 : 6'd0;
            OP_PASS: z = y;
            default: z = 6'd0;
        endcase
        return {iof, z[5], (z == 6'd0), z};
    endfunction

    // The external ALU the sequencer drives.
    always_comb begin
        {alu_iof, alu_baf, alu_zf, alu_z} = aluModel(alu_op, alu_x, alu_y);
    end

    // Watch for the terminator ever leaking onto the ALU opcode bus.
    always @(negedge clk) begin
        if (rst_n && busy && (alu_op == OP_END)) endSeen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference run: fold the stored program over the seed until END or the last slot.
    task automatic computeExpected(input logic [5:0] acc0, output logic [5:0] r, output int st,
                                   output logic iof, output logic baf, output logic zf, output int lat);
        logic [8:0] o;
        bit ended;
        ended = 1'b0;
        r = acc0; st = 0; iof = 1'b0; baf = 1'b0; zf = 1'b0;
        for (int i = 0; i < DEPTH && !ended; i++) begin
            if (progModel[i][9:6] == OP_END) begin
                ended = 1'b1;
            end else begin
                o   = aluModel(progModel[i][9:6], r, progModel[i][5:0]);
                r   = o[5:0];
                iof = iof | o[8];
                baf = baf | o[7];
                zf  = o[6];
                st++;
            end
        end
        lat = ended ? st + 1 : st;
    endtask

    // Program write of one slot, mirrored into the model.
    task automatic applyStimulus(input int addr, input logic [3:0] op, input logic [5:0] imm);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_op   = op;
        prog_imm  = imm;
        progModel[addr] = {op, imm};
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic loadProgram(input logic [9:0] p [DEPTH]);
        for (int i = 0; i < DEPTH; i++) applyStimulus(i, p[i][9:6], p[i][5:0]);
    endtask

    task automatic runAndCheck(input string tag, input logic [5:0] acc0, input bit disturb,
                               input bit wrSame, input logic [3:0] wrOp, input logic [5:0] wrImm);
        logic [5:0] expR;
        int expSt;
        logic expIof, expBaf, expZf;
        int expLat;
        int edges;
        @(negedge clk);
        start    = 1'b1;
        acc_init = acc0;
        if (wrSame) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_op   = wrOp;
            prog_imm  = wrImm;
            progModel[0] = {wrOp, wrImm};
        end
        computeExpected(acc0, expR, expSt, expIof, expBaf, expZf, expLat);
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        checkOutput({tag, " busy"}, 32'(busy), 32'd1);
        if (disturb) begin
            start     = 1'b1;
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_op   = 4'(($urandom_range(0, 14) + 1) % 16);
            prog_imm  = 6'($urandom);
        end
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start   = 1'b0;
            prog_we = 1'b0;
            if (done) break;
        end
        checkOutput({tag, " latency"}, 32'(edges), 32'(expLat));
        checkOutput({tag, " result"}, 32'(result), 32'(expR));
        checkOutput({tag, " steps"}, 32'(steps), 32'(expSt));
        checkOutput({tag, " iof"}, 32'(iof_sticky), 32'(expIof));
        checkOutput({tag, " baf"}, 32'(baf_sticky), 32'(expBaf));
        checkOutput({tag, " zf"}, 32'(zf_last), 32'(expZf));
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " done pulse"}, {30'd0, done, busy}, 32'd0);
        checkOutput({tag, " held"}, 32'(result), 32'(expR));
    endtask

    initial begin
        logic [9:0] p [DEPTH];
        int lo;
        int doneCount;
        checks = 0; errors = 0; endSeen = 0;
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_op = '0; prog_imm = '0;
        start = 1'b0; acc_init = '0;

        // Reset state.
        #12;
        checkOutput("reset busy/done", {30'd0, busy, done}, 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset steps", 32'(steps), 32'd0);
        checkOutput("reset flags", {29'd0, iof_sticky, baf_sticky, zf_last}, 32'd0);
        checkOutput("reset alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // NOT, INC, XOR 110010, END.
        p = '{{OP_NOT, 6'd0}, {OP_INC, 6'd0}, {OP_XOR, 6'b110010}, {OP_END, 6'd0},
              {OP_INC, 6'd0}, {OP_INC, 6'd0}, {OP_INC, 6'd0}, {OP_INC, 6'd0}};
        loadProgram(p);
        runAndCheck("prog1", 6'b001010, 1'b0, 1'b0, 4'd0, 6'd0);
        checkOutput("prog1 const result", 32'(result), 32'b000100);
        checkOutput("prog1 const steps", 32'(steps), 32'd3);
        checkOutput("prog1 const baf", 32'(baf_sticky), 32'd1);

        // ADD 100000, EQ 111111, END.
        applyStimulus(0, OP_ADD, 6'b100000);
        applyStimulus(1, OP_EQ, 6'b111111);
        applyStimulus(2, OP_END, 6'd0);
        runAndCheck("prog2", 6'b011111, 1'b0, 1'b0, 4'd0, 6'd0);
        checkOutput("prog2 const result", 32'(result), 32'd1);

        // All slots INC, no terminator.
        for (int i = 0; i < DEPTH; i++) p[i] = {OP_INC, 6'd0};
        loadProgram(p);
        runAndCheck("fill", 6'd0, 1'b0, 1'b0, 4'd0, 6'd0);
        checkOutput("fill const result", 32'(result), 32'd8);
        checkOutput("fill const steps", 32'(steps), 32'd8);

        // Terminator in slot 0.
        applyStimulus(0, OP_END, 6'd0);
        runAndCheck("end0", 6'b101101, 1'b0, 1'b0, 4'd0, 6'd0);
        checkOutput("end0 const result", 32'(result), 32'b101101);

        // start and program write during a run are ignored; rerun shows the RAM intact.
        p = '{{OP_SUB, 6'd3}, {OP_SHL, 6'd0}, {OP_OR, 6'b000101}, {OP_END, 6'd0},
              {OP_INC, 6'd0}, {OP_INC, 6'd0}, {OP_INC, 6'd0}, {OP_INC, 6'd0}};
        loadProgram(p);
        runAndCheck("disturb", 6'd20, 1'b1, 1'b0, 4'd0, 6'd0);
        runAndCheck("reread", 6'd20, 1'b0, 1'b0, 4'd0, 6'd0);

        // Write to slot 0 on the same edge as start takes effect for that run.
        runAndCheck("samedge", 6'd9, 1'b0, 1'b1, OP_NEG, 6'd0);

        // Reset in the middle of a three-step run.
        p = '{{OP_INC, 6'd0}, {OP_INC, 6'd0}, {OP_INC, 6'd0}, {OP_END, 6'd0},
              {OP_INC, 6'd0}, {OP_INC, 6'd0}, {OP_INC, 6'd0}, {OP_INC, 6'd0}};
        loadProgram(p);
        @(negedge clk);
        start = 1'b1; acc_init = 6'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset result", 32'(result), 32'd0);
        doneCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("midreset no done", 32'(doneCount), 32'd0);
        runAndCheck("after reset", 6'd5, 1'b0, 1'b0, 4'd0, 6'd0);

        // Randomised programs and seeds.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    p[i] = {OP_END, 6'($urandom)};
                end else begin
                    lo = $urandom_range(0, 14);
                    if (lo >= 1) lo++;
                    p[i] = {4'(lo), 6'($urandom)};
                end
            end
            loadProgram(p);
            runAndCheck($sformatf("rand%0d", t), 6'($urandom), 1'($urandom_range(0, 1)), 1'b0, 4'd0, 6'd0);
        end

        checkOutput("end op never issued", 32'(endSeen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
